// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns Hi/Lo, runs mult/div with
// fixed latency, services mthi/mtlo/mfhi/mflo and drives the D-stage stall.
//
// state | meaning
// IDLE  | no operation in flight, mthi/mtlo accepted
// RUN   | counting down, result commits to Hi/Lo when cnt reaches 1
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        md_valid,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] MD_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [31:0]  r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic         r_pend_ok;

  logic         w_issue, w_start, w_mthi, w_mtlo, w_commit, w_is_mult;
  logic         w_div_zero, w_div_ovf;
  logic [31:0]  w_div_s_b, w_div_u_b;
  logic signed [63:0] w_prod_s;
  logic [63:0]  w_prod_u;
  logic signed [31:0] w_quo_s, w_rem_s;
  logic [31:0]  w_quo_u, w_rem_u;
  logic [31:0]  w_res_hi, w_res_lo;
  logic         w_res_ok;

  assign busy      = (r_state == RUN);
  assign w_issue   = md_valid & ~cancel & ~busy;
  assign w_start   = w_issue & (md_op >= 4'b0001) & (md_op <= 4'b0100);
  assign w_is_mult = (md_op == 4'b0001) | (md_op == 4'b0010);
  assign w_mthi    = w_issue & (md_op == 4'b0101);
  assign w_mtlo    = w_issue & (md_op == 4'b1000);
  assign md_stall  = md_use_D & (busy | w_start);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Dividing by 1 in the overflow case yields exactly quotient=A, remainder=0.
  assign w_div_zero = (B == 32'd0);
  assign w_div_ovf  = (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
  assign w_div_s_b  = (w_div_zero | w_div_ovf) ? 32'd1 : B;
  assign w_div_u_b  = w_div_zero ? 32'd1 : B;
  assign w_quo_s    = $signed(A) / $signed(w_div_s_b);
  assign w_rem_s    = $signed(A) % $signed(w_div_s_b);
  assign w_quo_u    = A / w_div_u_b;
  assign w_rem_u    = A % w_div_u_b;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_ok = 1'b1;
    case (md_op)
      4'b0001: begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      4'b0010: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      4'b0011: begin w_res_hi = w_rem_s; w_res_lo = w_quo_s; w_res_ok = ~w_div_zero; end
      4'b0100: begin w_res_hi = w_rem_u; w_res_lo = w_quo_u; w_res_ok = ~w_div_zero; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = w_is_mult ? MULT_N : DIV_N;
        end
      end
      RUN: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_ok <= w_res_ok;
      end
      if (w_commit && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else begin
        if (w_mthi) r_hi <= A;
        if (w_mtlo) r_lo <= A;
      end
    end
  end

  assign Hi = r_hi;
  assign Lo = r_lo;

  always_comb begin
    MD_out = 32'd0;
    if (md_op == 4'b0110) MD_out = r_hi;
    else if (md_op == 4'b0111) MD_out = r_lo;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, results, stall, cancel and reset.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic        md_valid = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        md_use_D = 1'b0;
  logic        busy, md_stall;
  logic [31:0] Hi, Lo, MD_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .md_valid(md_valid),
    .cancel(cancel), .A(A), .B(B), .md_use_D(md_use_D), .busy(busy),
    .md_stall(md_stall), .Hi(Hi), .Lo(Lo), .MD_out(MD_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op; A = a; B = b; md_valid = 1'b1;
    @(negedge clk);
    md_valid = 1'b0; md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_hi", Hi, 32'd0);
    check_val("rst_lo", Lo, 32'd0);
    @(negedge clk) reset = 1'b1;

    issue(4'b0001, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cyc);
    check_val("mult_cyc", 32'(cyc), 32'd5);
    check_val("mult_hi", Hi, 32'hFFFF_FFFF);
    check_val("mult_lo", Lo, 32'hFFFF_FFFA);

    issue(4'b0010, 32'hFFFF_FFFE, 32'd3);
    wait_idle(cyc);
    check_val("multu_hi", Hi, 32'h0000_0002);
    check_val("multu_lo", Lo, 32'hFFFF_FFFA);

    issue(4'b0011, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    check_val("div_cyc", 32'(cyc), 32'd10);
    check_val("div_lo", Lo, 32'hFFFF_FFFD);
    check_val("div_hi", Hi, 32'hFFFF_FFFF);

    issue(4'b0100, 32'd7, 32'd0);
    wait_idle(cyc);
    check_val("divu0_cyc", 32'(cyc), 32'd10);
    check_val("divu0_hi", Hi, 32'hFFFF_FFFF);
    check_val("divu0_lo", Lo, 32'hFFFF_FFFD);

    issue(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check_val("divovf_lo", Lo, 32'h8000_0000);
    check_val("divovf_hi", Hi, 32'h0000_0000);

    issue(4'b0100, 32'd100, 32'd7);
    wait_idle(cyc);
    check_val("divu_lo", Lo, 32'd14);
    check_val("divu_hi", Hi, 32'd2);

    issue(4'b0101, 32'h1234_5678, 32'd0);
    check_val("mthi_busy", 32'(busy), 32'd0);
    check_val("mthi_hi", Hi, 32'h1234_5678);
    issue(4'b1000, 32'h9ABC_DEF0, 32'd0);
    check_val("mtlo_lo", Lo, 32'h9ABC_DEF0);
    check_val("mtlo_hi_kept", Hi, 32'h1234_5678);
    @(negedge clk) md_op = 4'b0110;
    #1 check_val("mfhi", MD_out, 32'h1234_5678);
    @(negedge clk) md_op = 4'b0111;
    #1 check_val("mflo", MD_out, 32'h9ABC_DEF0);
    @(negedge clk) md_op = 4'b0011;
    #1 check_val("mdout_other", MD_out, 32'd0);

    // stall across start and busy cycles; a second mult while busy is dropped
    @(negedge clk);
    md_op = 4'b0001; A = 32'h10; B = 32'h20; md_valid = 1'b1; md_use_D = 1'b1;
    #1 check_val("stall_start", 32'(md_stall), 32'd1);
    check_val("stall_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    md_valid = 1'b0; md_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      check_val($sformatf("stall_busy%0d", cyc), 32'(md_stall), 32'd1);
      if (cyc == 2) begin md_op = 4'b0001; A = 32'd5; B = 32'd7; md_valid = 1'b1; end
      if (cyc == 3) begin md_op = 4'd0; md_valid = 1'b0; end
      @(negedge clk);
    end
    check_val("stall_cyc", 32'(cyc), 32'd5);
    check_val("stall_after", 32'(md_stall), 32'd0);
    check_val("second_ign_hi", Hi, 32'd0);
    check_val("second_ign_lo", Lo, 32'h200);
    md_use_D = 1'b0;

    @(negedge clk);
    md_op = 4'b0001; A = 32'd2; B = 32'd2; md_valid = 1'b1; cancel = 1'b1; md_use_D = 1'b1;
    #1 check_val("cancel_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    check_val("cancel_busy", 32'(busy), 32'd0);
    md_valid = 1'b0; md_op = 4'd0; cancel = 1'b0; md_use_D = 1'b0;
    repeat (6) @(negedge clk);
    check_val("cancel_hi", Hi, 32'd0);
    check_val("cancel_lo", Lo, 32'h200);

    issue(4'b0001, 32'd3, 32'd4);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin cancel = 1'b1; md_valid = 1'b1; end
      if (cyc == 3) begin cancel = 1'b0; md_valid = 1'b0; end
      @(negedge clk);
    end
    check_val("runcancel_cyc", 32'(cyc), 32'd5);
    check_val("runcancel_lo", Lo, 32'd12);
    check_val("runcancel_hi", Hi, 32'd0);

    issue(4'b0101, 32'hDEAD_BEEF, 32'd0);
    issue(4'b0011, 32'd100, 32'd7);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 4) begin
        #2 reset = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_hi", Hi, 32'd0);
        check_val("arst_lo", Lo, 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk) reset = 1'b1;
    repeat (15) @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    check_val("post_rst_hi", Hi, 32'd0);
    check_val("post_rst_lo", Lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It owns the Hi/Lo registers and executes mult/multu/div/divu with fixed configurable latency. It services mthi/mtlo/mfhi/mflo and raises the stall request that holds an MD-class instruction in D while an operation is in flight. MD_out feeds the W-stage MDO_W path of the register-file write-data select.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state
md_op  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 1000 mtlo, 0110 mfhi, 0111 mflo
md_valid  input  1  E-stage instruction is real (not bubble)
cancel  input  1  E-stage instruction flushed by exception/interrupt this cycle
A  input  32  forwarded rs value (MFRSE)
B  input  32  forwarded rt value (MFRTE)
md_use_D  input  1  instruction in D is any MD-class op (md_op != 0000)
busy  output  1  operation in flight
md_stall  output  1  stall request to hazard unit
Hi  output  32  Hi register
Lo  output  32  Lo register
MD_out  output  32  0110 -> Hi, 0111 -> Lo, else 0 (combinational)

Behaviour:
- Reset (reset=0, asynchronous): busy=0, Hi=0, Lo=0, internal counter=0, pending results=0; states IDLE.
- States: IDLE, RUN. start = md_valid & ~cancel & ~busy & md_op in {0001..0100}.
- IDLE->RUN on start: the start edge captures the full result into pending_hi/pending_lo and loads cnt with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
- RUN: cnt decrements each edge. On the edge where cnt==1: Hi<=pending_hi, Lo<=pending_lo, busy<=0, go to IDLE. busy is high for exactly N cycles, and new Hi/Lo are visible in the first cycle busy=0.
- mult: signed 32x32 -> 64, Hi=[63:32], Lo=[31:0]. multu: unsigned.
- div: signed; quotient truncates toward zero -> Lo; remainder takes the sign of the dividend -> Hi. divu: unsigned.
- Special case 0x80000000 / 0xFFFFFFFF (div): Lo=0x80000000, Hi=0.
- Divisor 0: the operation still runs DIV_CYCLES, but Hi/Lo are left unchanged at commit.
- mthi/mtlo (md_valid & ~cancel & ~busy): Hi<=A or Lo<=A on that edge, with no busy. If presented while busy, the op is ignored.
- start while busy: ignored. The hazard unit guarantees this does not occur.
- cancel with start in the same cycle: start is suppressed, state stays IDLE, Hi/Lo untouched.
- cancel while in RUN: no abort; the operation completes and commits (MIPS semantics).
- md_stall = md_use_D & (busy | start). It is combinational and asserts in the start cycle, so an MD op in D never observes stale Hi/Lo.
- mfhi/mflo: MD_out reflects current Hi/Lo combinationally. Read while busy is prevented by md_stall.
- reset asserted mid-RUN: immediate return to IDLE, busy=0, Hi=Lo=0, pending result discarded.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, md_valid=1 -> busy high for 5 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. multu with the same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles; then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. divu 7/0 -> busy high 10 cycles, Hi/Lo unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0, then mfhi and mflo -> MD_out=0x12345678, then 0x9ABCDEF0. An unrelated md_op -> MD_out=0.
- mult started with md_use_D=1 in the same cycle -> md_stall=1 in the start cycle and for all 5 busy cycles, 0 after. A second mult presented while busy -> ignored, first result intact.
- mult with cancel=1 in the start cycle -> busy stays 0, Hi/Lo unchanged. cancel=1 pulsed during RUN -> result still commits.
- Start div, then drive reset=0 at busy cycle 4 asynchronously -> busy=0 and Hi=Lo=0 immediately; after release, no commit occurs.
